video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator for the dual-projector HDMI path, driven from clock_pixel.
//  Holds two timing sets, selected at run time and switched only on frame boundaries.
//  Gates raster start and stop on frame boundaries via HDMI_START.
//  Provides pixel coordinates, a line-buffer request window, line/frame strobes and a left/right eye flag for frame-sequential stereo.
// PARAMETERS
//  CW            12    counter/coordinate width in bits
//  M0_HA/HF/HS/HB 800/48/32/80   mode 0 horizontal: active, front porch, sync, back porch (800x600@120)
//  M0_VA/VF/VS/VB 600/3/4/29     mode 0 vertical timing
//  M1_HA/HF/HS/HB 800/40/128/88  mode 1 horizontal timing (800x600@60)
//  M1_VA/VF/VS/VB 600/1/4/23     mode 1 vertical timing
//  HS_POL        0     active level of SYNC_H (0 = active-low)
//  VS_POL        0     active level of SYNC_V
//  FCW           16    frame counter width
// PORTS
//  clock_pixel  in  1      pixel clock; all logic on its rising edge
//  reset        in  1      synchronous, active-high
//  HDMI_START   in  1      run request; sampled only in IDLE and at last pixel of frame
//  iMode        in  1      timing set request; sampled with HDMI_START
//  SYNC_H       out 1      horizontal sync, polarity HS_POL
//  SYNC_V       out 1      vertical sync, polarity VS_POL
//  DE           out 1      active video
//  oRequest     out 1      line-fetch window: y==VT-1 or y<VA
//  oX, oY       out CW     coordinates of current pixel (valid when DE)
//  oLineStart   out 1      1-cycle strobe, x==0
//  oFrameStart  out 1      1-cycle strobe, x==0 and y==0
//  oEye         out 1      0 = left, 1 = right; toggles at each frame start after the first
//  oFrameCount  out FCW    frames started since leaving IDLE (wraps)
//  oMode        out 1      timing set currently in use
// BEHAVIOUR
//  Totals: HT = HA+HF+HS+HB, VT = VA+VF+VS+VB of the active set (mode 0: 960x636, mode 1: 1056x628).
//  FSM states:
//   IDLE: counters x=y=0.
//   IDLE -> RUN when HDMI_START=1. Latch oMode<=iMode; next cycle x=0,y=0.
//   RUN: x increments and wraps at HT-1; y increments when x==HT-1 and wraps at VT-1.
//   At x==HT-1 && y==VT-1 (last pixel), sample HDMI_START and iMode:
//    - start=0: go to IDLE.
//    - else: oMode<=iMode, effective from the next x=0,y=0.
//   Mode is never changed mid-frame.
//  Outputs are registered: one cycle latency from counter value (x,y) to all outputs.
//   SYNC_H active when HA+HF <= x < HA+HF+HS.
//   SYNC_V active when VA+VF <= y < VA+VF+VS.
//   DE = x<HA && y<VA; oX=x, oY=y.
//  In IDLE (and after reset): DE=0, oRequest=0, strobes=0, SYNC_H/SYNC_V at inactive level, oX=oY=0.
//  Reset values: oEye=0, oFrameCount=0, oMode=0, state IDLE.
//  Stereo and frame counting:
//   First oFrameStart after IDLE->RUN: oEye=0, oFrameCount=1.
//   Each later oFrameStart: toggle oEye, increment oFrameCount (wrap 2^FCW-1 -> 0).
//   RUN->IDLE->RUN restarts the eye at 0.
//  reset=1 overrides everything in the same cycle, including mid-frame; outputs reach reset values on the next edge.
//  HDMI_START and iMode changes mid-frame are ignored.
// TESTING
//  T1 reset, HDMI_START=1, iMode=0, two frames:
//     DE high 800 cycles/line; period 960; 600 active lines; frame = 610560 cycles; SYNC_H low x=848..879.
//  T2 iMode 0->1 mid-frame:
//     current frame keeps HT=960; next frame HT=1056, SYNC_H low x=840..967, oMode=1 at its oFrameStart.
//  T3 HDMI_START deasserted mid-frame:
//     frame completes; then IDLE: DE=0, syncs inactive; reassert -> oFrameStart 2 cycles later, oEye=0, oFrameCount=1.
//  T4 run 3 frames:
//     oEye 0,1,0; oFrameCount 1,2,3; oRequest high y=0..599 and y=635; FCW=2 wrap check 3 -> 0.
//  T5 reset pulse at x=400,y=300:
//     next cycle all outputs at reset values; restart from x=0,y=0 with oEye=0.
//  T6 HS_POL=1, VS_POL=1:
//     SYNC_H/SYNC_V high only in pulse windows; low in IDLE.

Source files
------------

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Raster timing generator for the dual-projector HDMI path.
//               Two compile-time timing sets, chosen at run time and only
//               swapped on frame boundaries. Raster start/stop is gated on
//               frame boundaries by HDMI_START. Emits syncs, DE, pixel
//               coordinates, a line-fetch request window, line/frame strobes,
//               a frame-sequential stereo eye flag and a frame counter.
// Ports       : clock_pixel, reset (sync, active-high)
//               HDMI_START  run request (sampled in IDLE / last pixel)
//               iMode       timing set request (sampled with HDMI_START)
//               SYNC_H, SYNC_V, DE, oRequest, oX, oY, oLineStart,
//               oFrameStart, oEye, oFrameCount, oMode  (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int CW     = 12,
    parameter int M0_HA  = 800,
    parameter int M0_HF  = 48,
    parameter int M0_HS  = 32,
    parameter int M0_HB  = 80,
    parameter int M0_VA  = 600,
    parameter int M0_VF  = 3,
    parameter int M0_VS  = 4,
    parameter int M0_VB  = 29,
    parameter int M1_HA  = 800,
    parameter int M1_HF  = 40,
    parameter int M1_HS  = 128,
    parameter int M1_HB  = 88,
    parameter int M1_VA  = 600,
    parameter int M1_VF  = 1,
    parameter int M1_VS  = 4,
    parameter int M1_VB  = 23,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int FCW    = 16
) (
    input  logic           clock_pixel,
    input  logic           reset,
    input  logic           HDMI_START,
    input  logic           iMode,
    output logic           SYNC_H,
    output logic           SYNC_V,
    output logic           DE,
    output logic           oRequest,
    output logic [CW-1:0]  oX,
    output logic [CW-1:0]  oY,
    output logic           oLineStart,
    output logic           oFrameStart,
    output logic           oEye,
    output logic [FCW-1:0] oFrameCount,
    output logic           oMode
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Per-mode constants, pre-computed so only a mux sits in the compare path
    localparam logic [CW-1:0] c_M0_HA      = CW'(M0_HA);
    localparam logic [CW-1:0] c_M0_VA      = CW'(M0_VA);
    localparam logic [CW-1:0] c_M0_HS_BEG  = CW'(M0_HA + M0_HF);
    localparam logic [CW-1:0] c_M0_HS_END  = CW'(M0_HA + M0_HF + M0_HS);
    localparam logic [CW-1:0] c_M0_VS_BEG  = CW'(M0_VA + M0_VF);
    localparam logic [CW-1:0] c_M0_VS_END  = CW'(M0_VA + M0_VF + M0_VS);
    localparam logic [CW-1:0] c_M0_HT_LAST = CW'(M0_HA + M0_HF + M0_HS + M0_HB - 1);
    localparam logic [CW-1:0] c_M0_VT_LAST = CW'(M0_VA + M0_VF + M0_VS + M0_VB - 1);
    localparam logic [CW-1:0] c_M1_HA      = CW'(M1_HA);
    localparam logic [CW-1:0] c_M1_VA      = CW'(M1_VA);
    localparam logic [CW-1:0] c_M1_HS_BEG  = CW'(M1_HA + M1_HF);
    localparam logic [CW-1:0] c_M1_HS_END  = CW'(M1_HA + M1_HF + M1_HS);
    localparam logic [CW-1:0] c_M1_VS_BEG  = CW'(M1_VA + M1_VF);
    localparam logic [CW-1:0] c_M1_VS_END  = CW'(M1_VA + M1_VF + M1_VS);
    localparam logic [CW-1:0] c_M1_HT_LAST = CW'(M1_HA + M1_HF + M1_HS + M1_HB - 1);
    localparam logic [CW-1:0] c_M1_VT_LAST = CW'(M1_VA + M1_VF + M1_VS + M1_VB - 1);
    localparam logic [CW-1:0]  c_ONE       = CW'(1);
    localparam logic [FCW-1:0] c_FCNT_ONE  = FCW'(1);

    logic [0:0]     r_state;
    logic [0:0]     w_state_next;
    logic           w_load_mode;
    logic           r_mode;
    logic [CW-1:0]  r_x;
    logic [CW-1:0]  r_y;

    logic [CW-1:0]  w_ha, w_va, w_hs_beg, w_hs_end, w_vs_beg, w_vs_end;
    logic [CW-1:0]  w_ht_last, w_vt_last;
    logic           w_run, w_x_last, w_last_pixel, w_first_pixel;

    logic           r_hsync, r_vsync, r_de, r_req, r_line_start, r_frame_start;
    logic [CW-1:0]  r_ox, r_oy;
    logic           r_eye, r_first;
    logic [FCW-1:0] r_fcnt;

    // Timing of the set currently in use
    assign w_ha      = r_mode ? c_M1_HA      : c_M0_HA;
    assign w_va      = r_mode ? c_M1_VA      : c_M0_VA;
    assign w_hs_beg  = r_mode ? c_M1_HS_BEG  : c_M0_HS_BEG;
    assign w_hs_end  = r_mode ? c_M1_HS_END  : c_M0_HS_END;
    assign w_vs_beg  = r_mode ? c_M1_VS_BEG  : c_M0_VS_BEG;
    assign w_vs_end  = r_mode ? c_M1_VS_END  : c_M0_VS_END;
    assign w_ht_last = r_mode ? c_M1_HT_LAST : c_M0_HT_LAST;
    assign w_vt_last = r_mode ? c_M1_VT_LAST : c_M0_VT_LAST;

    assign w_run         = (r_state == c_ST_RUN);
    assign w_x_last      = (r_x == w_ht_last);
    assign w_last_pixel  = w_x_last && (r_y == w_vt_last);
    assign w_first_pixel = (r_x == '0) && (r_y == '0);

    // Next state; HDMI_START/iMode only matter in IDLE or on the last pixel
    always_comb begin
        w_state_next = r_state;
        w_load_mode  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (HDMI_START) begin
                    w_state_next = c_ST_RUN;
                    w_load_mode  = 1'b1;
                end
            end
            c_ST_RUN: begin
                if (w_last_pixel) begin
                    if (!HDMI_START) begin
                        w_state_next = c_ST_IDLE;
                    end else begin
                        w_load_mode  = 1'b1;
                    end
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_pixel) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load_mode) begin
                r_mode <= iMode;
            end
        end
    end

    // Raster counters; held at the origin while idle so RUN starts at (0,0)
    always_ff @(posedge clock_pixel) begin
        if (reset || !w_run) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_x_last) begin
            r_x <= '0;
            r_y <= (r_y == w_vt_last) ? '0 : (r_y + c_ONE);
        end else begin
            r_x <= r_x + c_ONE;
        end
    end

    // Output stage: one register between counter value and every output
    always_ff @(posedge clock_pixel) begin
        if (reset) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_de          <= 1'b0;
            r_req         <= 1'b0;
            r_ox          <= '0;
            r_oy          <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= (w_run && (r_x >= w_hs_beg) && (r_x < w_hs_end)) ? HS_POL : ~HS_POL;
            r_vsync       <= (w_run && (r_y >= w_vs_beg) && (r_y < w_vs_end)) ? VS_POL : ~VS_POL;
            r_de          <= w_run && (r_x < w_ha) && (r_y < w_va);
            // Request opens one line early so the first active line is prefetched
            r_req         <= w_run && ((r_y == w_vt_last) || (r_y < w_va));
            r_ox          <= w_run ? r_x : '0;
            r_oy          <= w_run ? r_y : '0;
            r_line_start  <= w_run && (r_x == '0);
            r_frame_start <= w_run && w_first_pixel;
        end
    end

    // Stereo eye and frame count advance together with oFrameStart.
    // r_first marks the first frame after leaving IDLE, which restarts the eye.
    always_ff @(posedge clock_pixel) begin
        if (reset) begin
            r_eye   <= 1'b0;
            r_fcnt  <= '0;
            r_first <= 1'b1;
        end else if (!w_run) begin
            r_first <= 1'b1;
        end else if (w_first_pixel) begin
            if (r_first) begin
                r_eye   <= 1'b0;
                r_fcnt  <= c_FCNT_ONE;
                r_first <= 1'b0;
            end else begin
                r_eye   <= ~r_eye;
                r_fcnt  <= r_fcnt + c_FCNT_ONE;
            end
        end
    end

    assign SYNC_H      = r_hsync;
    assign SYNC_V      = r_vsync;
    assign DE          = r_de;
    assign oRequest    = r_req;
    assign oX          = r_ox;
    assign oY          = r_oy;
    assign oLineStart  = r_line_start;
    assign oFrameStart = r_frame_start;
    assign oEye        = r_eye;
    assign oFrameCount = r_fcnt;
    assign oMode       = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Randomised self-checking bench for video_timing_gen. Two DUTs
//               (active-low and active-high syncs) share stimulus; a frame
//               position model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int CW  = 8;
    localparam int FCW = 2;

    // Reduced rasters so many frames, mode switches and counter wraps fit
    int HA [2] = '{8, 10};
    int HF [2] = '{2, 1};
    int HS [2] = '{3, 4};
    int HB [2] = '{2, 3};
    int VA [2] = '{4, 5};
    int VF [2] = '{1, 2};
    int VS [2] = '{2, 1};
    int VB [2] = '{1, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic imode = 1'b0;

    logic           a_hs, a_vs, a_de, a_req, a_ls, a_fs, a_eye, a_mode;
    logic [CW-1:0]  a_x, a_y;
    logic [FCW-1:0] a_cnt;
    logic           b_hs, b_vs, b_de, b_req, b_ls, b_fs, b_eye, b_mode;
    logic [CW-1:0]  b_x, b_y;
    logic [FCW-1:0] b_cnt;

    always #5 clk = ~clk;

    video_timing_gen #(
        .CW(CW),
        .M0_HA(8),  .M0_HF(2), .M0_HS(3), .M0_HB(2),
        .M0_VA(4),  .M0_VF(1), .M0_VS(2), .M0_VB(1),
        .M1_HA(10), .M1_HF(1), .M1_HS(4), .M1_HB(3),
        .M1_VA(5),  .M1_VF(2), .M1_VS(1), .M1_VB(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .FCW(FCW)
    ) u_dut_a (
        .clock_pixel(clk), .reset(rst), .HDMI_START(start), .iMode(imode),
        .SYNC_H(a_hs), .SYNC_V(a_vs), .DE(a_de), .oRequest(a_req),
        .oX(a_x), .oY(a_y), .oLineStart(a_ls), .oFrameStart(a_fs),
        .oEye(a_eye), .oFrameCount(a_cnt), .oMode(a_mode)
    );

    video_timing_gen #(
        .CW(CW),
        .M0_HA(8),  .M0_HF(2), .M0_HS(3), .M0_HB(2),
        .M0_VA(4),  .M0_VF(1), .M0_VS(2), .M0_VB(1),
        .M1_HA(10), .M1_HF(1), .M1_HS(4), .M1_HB(3),
        .M1_VA(5),  .M1_VF(2), .M1_VS(1), .M1_VB(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .FCW(FCW)
    ) u_dut_b (
        .clock_pixel(clk), .reset(rst), .HDMI_START(start), .iMode(imode),
        .SYNC_H(b_hs), .SYNC_V(b_vs), .DE(b_de), .oRequest(b_req),
        .oX(b_x), .oY(b_y), .oLineStart(b_ls), .oFrameStart(b_fs),
        .oEye(b_eye), .oFrameCount(b_cnt), .oMode(b_mode)
    );

    typedef struct packed {
        logic           hs_act;
        logic           vs_act;
        logic           de;
        logic           req;
        logic [CW-1:0]  x;
        logic [CW-1:0]  y;
        logic           ls;
        logic           fs;
        logic           eye;
        logic [FCW-1:0] cnt;
        logic           mode;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

    // Reference model: the raster is a single linear position within a frame
    bit       m_run   = 1'b0;
    bit       m_mode  = 1'b0;
    bit       m_fresh = 1'b0;
    bit       m_eye   = 1'b0;
    bit [1:0] m_cnt   = 2'd0;
    int       m_pos   = 0;

    task automatic model_step(input bit r, input bit st, input bit md);
        exp_t e;
        int   ht, vt, x, y;
        e = '0;
        if (r) begin
            m_run = 1'b0; m_mode = 1'b0; m_eye = 1'b0; m_cnt = 2'd0; m_pos = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1'b1; m_mode = md; m_fresh = 1'b1; m_pos = 0;
            end
        end else begin
            ht = HA[m_mode] + HF[m_mode] + HS[m_mode] + HB[m_mode];
            vt = VA[m_mode] + VF[m_mode] + VS[m_mode] + VB[m_mode];
            x  = m_pos % ht;
            y  = m_pos / ht;
            e.de     = (x < HA[m_mode]) && (y < VA[m_mode]);
            e.hs_act = (x >= HA[m_mode] + HF[m_mode]) && (x < HA[m_mode] + HF[m_mode] + HS[m_mode]);
            e.vs_act = (y >= VA[m_mode] + VF[m_mode]) && (y < VA[m_mode] + VF[m_mode] + VS[m_mode]);
            e.req    = (y == vt - 1) || (y < VA[m_mode]);
            e.x      = CW'(x);
            e.y      = CW'(y);
            e.ls     = (x == 0);
            e.fs     = (m_pos == 0);
            if (m_pos == 0) begin
                if (m_fresh) begin
                    m_eye = 1'b0; m_cnt = 2'd1; m_fresh = 1'b0;
                end else begin
                    m_eye = ~m_eye; m_cnt = m_cnt + 2'd1;
                end
            end
            if (m_pos == ht * vt - 1) begin
                m_pos = 0;
                if (!st) m_run = 1'b0;
                else     m_mode = md;
            end else begin
                m_pos = m_pos + 1;
            end
        end
        e.eye  = m_eye;
        e.cnt  = m_cnt;
        e.mode = m_mode;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit st, input bit md);
        @(negedge clk);
        rst   = r;
        start = st;
        imode = md;
        model_step(r, st, md);
    endtask

    // Monitor: one expected entry per clock, compared against both DUTs
    initial begin
        exp_t e;
        logic [25:0] want, got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                want = {~e.hs_act, ~e.vs_act, e.de, e.req, e.x, e.y, e.ls, e.fs, e.eye, e.cnt, e.mode};
                got  = {a_hs, a_vs, a_de, a_req, a_x, a_y, a_ls, a_fs, a_eye, a_cnt, a_mode};
                n_total++;
                if (got === want) n_pass++;
                else $display("FAIL cyc %0d dut_a_outputs got=%h want=%h", cyc, got, want);
                want = {e.hs_act, e.vs_act, e.de, e.req, e.x, e.y, e.ls, e.fs, e.eye, e.cnt, e.mode};
                got  = {b_hs, b_vs, b_de, b_req, b_x, b_y, b_ls, b_fs, b_eye, b_cnt, b_mode};
                n_total++;
                if (got === want) n_pass++;
                else $display("FAIL cyc %0d dut_b_outputs got=%h want=%h", cyc, got, want);
            end
        end
    end

    initial begin
        int pct;
        // Reset held for a few cycles: checks reset values on both DUTs
        for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        // Segments alternate continuous running with frequent stop/start
        for (int s = 0; s < 12; s++) begin
            case (s % 4)
                0:       pct = 100;
                1:       pct = 97;
                2:       pct = 60;
                default: pct = 100;
            endcase
            for (int c = 0; c < 500; c++) begin
                drive(($urandom_range(0, 599) == 0),
                      ($urandom_range(0, 99) < pct),
                      1'($urandom_range(0, 1)));
            end
        end
        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
